// File: rtl/tnkiii_video_pkg.sv
// Shared constants for the TNK III video back-end line buffers.
// Holds line length, transparent pen and blank pixel value used by all back layers.
package tnkiii_video_pkg;

  localparam int         LINE_W_DEF    = 256;
  localparam logic [3:0] TRANS_PEN_DEF = 4'hF;
  localparam logic [7:0] BLANK_PIX     = 8'hFF;

  function automatic logic is_opaque(input logic [3:0] pen, input logic [3:0] trans_pen);
    return pen != trans_pen;
  endfunction

endpackage

// File: rtl/tnkiii_back1_linebuf_sram.sv
// Simple dual-port synchronous RAM: port 0 write-only, port 1 registered read.
// Contents are never reset.
module SRAM_dual_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic                  we0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  output logic [DATA_WIDTH-1:0] q1_o
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we0_i) mem[addr0_i] <= data0_i;
  end

  always_ff @(posedge clk) begin
    q1_o <= mem[addr1_i];
  end

endmodule

// File: rtl/tnkiii_back1_linebuf.sv
// Back1 ping-pong scanline buffer: one line is written while the previous one is
// read out (optionally mirrored), with a two-clock read pipeline.
module tnkiii_back1_linebuf
  import tnkiii_video_pkg::*;
#(
  parameter int         LINE_W    = LINE_W_DEF,
  parameter logic [3:0] TRANS_PEN = TRANS_PEN_DEF
) (
  input  logic       clk,
  input  logic       VIDEO_RSTn,
  input  logic       CK1n,
  input  logic       LSTART,
  input  logic       INV,
  input  logic [7:0] B1D,
  output logic [7:0] B1_PIX,
  output logic       B1_OPQ,
  output logic       B1_VALID,
  output logic       SHORT_LINE
);

  localparam int IDX_W  = $clog2(LINE_W);
  localparam int CNT_W  = IDX_W + 1;
  localparam int ADDR_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LINE_END = CNT_W'(LINE_W);

  logic             bank_sel_q, bank_sel_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_blank_q, rd_blank_d;
  logic [7:0]       pix_q, pix_d;
  logic             opq_q, opq_d;
  logic             valid_q, valid_d;
  logic             short_q, short_d;

  logic             wr_bank;
  logic [CNT_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_en, rd_in_line;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0]       ram_q;

  // A strobe coincident with LSTART already sees the new bank and address 0.
  always_comb begin
    wr_bank    = LSTART ? ~bank_sel_q : bank_sel_q;
    wr_ptr     = LSTART ? '0 : wr_cnt_q;
    rd_ptr     = LSTART ? '0 : rd_cnt_q;
    rd_in_line = rd_ptr < LINE_END;
    rd_idx     = INV ? ~rd_ptr[IDX_W-1:0] : rd_ptr[IDX_W-1:0];
    wr_en      = VIDEO_RSTn && CK1n && (wr_ptr < LINE_END);
    wr_addr    = {wr_bank, wr_ptr[IDX_W-1:0]};
    rd_addr    = {~wr_bank, rd_idx};
  end

  SRAM_dual_sync #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(ADDR_W)
  ) u_ram (
    .clk     (clk),
    .addr0_i (wr_addr),
    .data0_i (B1D),
    .we0_i   (wr_en),
    .addr1_i (rd_addr),
    .q1_o    (ram_q)
  );

  always_comb begin
    bank_sel_d = wr_bank;
    wr_cnt_d   = wr_en ? wr_ptr + CNT_W'(1) : wr_ptr;
    rd_cnt_d   = (CK1n && rd_in_line) ? rd_ptr + CNT_W'(1) : rd_ptr;
    rd_vld_d   = CK1n;
    rd_blank_d = ~rd_in_line;
    short_d    = LSTART && (wr_cnt_q < LINE_END);
    valid_d    = rd_vld_q;
    pix_d      = pix_q;
    if (rd_vld_q) pix_d = rd_blank_q ? BLANK_PIX : ram_q;
    opq_d      = is_opaque(pix_d[3:0], TRANS_PEN);
  end

  // Reset saturates both counters so nothing is written and reads are blank until LSTART.
  always_ff @(posedge clk) begin
    if (!VIDEO_RSTn) begin
      bank_sel_q <= 1'b0;
      wr_cnt_q   <= LINE_END;
      rd_cnt_q   <= LINE_END;
      rd_vld_q   <= 1'b0;
      rd_blank_q <= 1'b1;
      pix_q      <= BLANK_PIX;
      opq_q      <= 1'b0;
      valid_q    <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      bank_sel_q <= bank_sel_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_blank_q <= rd_blank_d;
      pix_q      <= pix_d;
      opq_q      <= opq_d;
      valid_q    <= valid_d;
      short_q    <= short_d;
    end
  end

  assign B1_PIX     = pix_q;
  assign B1_OPQ     = opq_q;
  assign B1_VALID   = valid_q;
  assign SHORT_LINE = short_q;

endmodule

// File: tb/tb_tnkiii_back1_linebuf.sv
// Directed self-checking bench for the Back1 line buffer with LINE_W = 256.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tnkiii_back1_linebuf;

  logic       clk = 1'b0;
  logic       VIDEO_RSTn = 1'b0;
  logic       CK1n = 1'b0;
  logic       LSTART = 1'b0;
  logic       INV = 1'b0;
  logic [7:0] B1D = 8'h00;
  logic [7:0] B1_PIX;
  logic       B1_OPQ, B1_VALID, SHORT_LINE;

  int tests = 0;
  int fails = 0;

  logic [7:0] cap_pix [0:299];
  logic       cap_vld [0:299];
  logic       cap_opq [0:299];
  logic       short_first;
  int         short_cnt;

  tnkiii_back1_linebuf dut (
    .clk        (clk),
    .VIDEO_RSTn (VIDEO_RSTn),
    .CK1n       (CK1n),
    .LSTART     (LSTART),
    .INV        (INV),
    .B1D        (B1D),
    .B1_PIX     (B1_PIX),
    .B1_OPQ     (B1_OPQ),
    .B1_VALID   (B1_VALID),
    .SHORT_LINE (SHORT_LINE)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    VIDEO_RSTn = 1'b0; CK1n = 1'b0; LSTART = 1'b0; INV = 1'b0; B1D = 8'h00;
    repeat (2) @(negedge clk);
    VIDEO_RSTn = 1'b1;
  endtask

  // Issues n back-to-back strobes and records the output belonging to each strobe
  // two clocks later; pixel data is index ^ xorv, and 8'hEE past the line end.
  task automatic run_line(input int n, input logic ls, input logic inv, input logic [7:0] xorv);
    short_first = 1'b0;
    short_cnt   = 0;
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        cap_pix[k-2] = B1_PIX;
        cap_vld[k-2] = B1_VALID;
        cap_opq[k-2] = B1_OPQ;
      end
      if (k == 1) short_first = SHORT_LINE;
      if (k >= 1 && SHORT_LINE) short_cnt++;
      CK1n   = (k < n);
      LSTART = ls && (k == 0);
      INV    = inv;
      B1D    = (k >= 256) ? 8'hEE : (8'(k) ^ xorv);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    VIDEO_RSTn = 1'b0; CK1n = 1'b1; LSTART = 1'b0; B1D = 8'h12;
    repeat (2) @(negedge clk);
    tests++;
    if (B1_PIX !== 8'hFF || B1_OPQ !== 1'b0 || B1_VALID !== 1'b0 || SHORT_LINE !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_values got pix=%h opq=%b vld=%b short=%b exp pix=ff opq=0 vld=0 short=0",
               B1_PIX, B1_OPQ, B1_VALID, SHORT_LINE);
    end
    CK1n = 1'b0;
    VIDEO_RSTn = 1'b1;
    run_line(4, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (cap_vld[k] !== 1'b1 || cap_pix[k] !== 8'hFF || cap_opq[k] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL pre_lstart_read k=%0d got vld=%b pix=%h opq=%b exp vld=1 pix=ff opq=0",
                 k, cap_vld[k], cap_pix[k], cap_opq[k]);
      end
    end
    tests++;
    if (short_cnt !== 0) begin
      fails++;
      $display("[TB] FAIL pre_lstart_short got %0d exp 0", short_cnt);
    end
  endtask

  task automatic test_fill_readback();
    do_reset();
    run_line(256, 1'b1, 1'b0, 8'h00);
    tests++;
    if (short_cnt !== 0) begin
      fails++;
      $display("[TB] FAIL first_lstart_short got %0d exp 0", short_cnt);
    end
    run_line(256, 1'b1, 1'b0, 8'hA5);
    for (int k = 0; k < 256; k++) begin
      tests++;
      if (cap_vld[k] !== 1'b1 || cap_pix[k] !== 8'(k)) begin
        fails++;
        $display("[TB] FAIL fill_readback k=%0d got vld=%b pix=%h exp vld=1 pix=%h",
                 k, cap_vld[k], cap_pix[k], 8'(k));
      end
    end
    tests++;
    if (short_cnt !== 0) begin
      fails++;
      $display("[TB] FAIL full_line_short got %0d exp 0", short_cnt);
    end
  endtask

  task automatic test_flip();
    do_reset();
    run_line(256, 1'b1, 1'b0, 8'h00);
    run_line(256, 1'b1, 1'b1, 8'h5A);
    for (int k = 0; k < 256; k++) begin
      tests++;
      if (cap_vld[k] !== 1'b1 || cap_pix[k] !== 8'(255 - k)) begin
        fails++;
        $display("[TB] FAIL flip_readback k=%0d got vld=%b pix=%h exp vld=1 pix=%h",
                 k, cap_vld[k], cap_pix[k], 8'(255 - k));
      end
    end
  endtask

  task automatic test_short_line();
    logic [7:0] exp_pix;
    do_reset();
    run_line(256, 1'b1, 1'b0, 8'h00);
    run_line(256, 1'b1, 1'b0, 8'hC3);
    run_line(100, 1'b1, 1'b0, 8'h3C);
    tests++;
    if (short_cnt !== 0) begin
      fails++;
      $display("[TB] FAIL short_after_full got %0d exp 0", short_cnt);
    end
    run_line(256, 1'b1, 1'b0, 8'h00);
    tests++;
    if (short_first !== 1'b1 || short_cnt !== 1) begin
      fails++;
      $display("[TB] FAIL short_pulse got first=%b count=%0d exp first=1 count=1", short_first, short_cnt);
    end
    for (int k = 0; k < 256; k++) begin
      exp_pix = (k < 100) ? (8'(k) ^ 8'h3C) : 8'(k);
      tests++;
      if (cap_vld[k] !== 1'b1 || cap_pix[k] !== exp_pix) begin
        fails++;
        $display("[TB] FAIL short_stale k=%0d got vld=%b pix=%h exp vld=1 pix=%h",
                 k, cap_vld[k], cap_pix[k], exp_pix);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    run_line(300, 1'b1, 1'b0, 8'h00);
    for (int k = 256; k < 300; k++) begin
      tests++;
      if (cap_vld[k] !== 1'b1 || cap_pix[k] !== 8'hFF || cap_opq[k] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL overrun_blank1 k=%0d got vld=%b pix=%h opq=%b exp vld=1 pix=ff opq=0",
                 k, cap_vld[k], cap_pix[k], cap_opq[k]);
      end
    end
    run_line(300, 1'b1, 1'b0, 8'h77);
    for (int k = 0; k < 300; k++) begin
      tests++;
      if (cap_vld[k] !== 1'b1 || cap_pix[k] !== ((k < 256) ? 8'(k) : 8'hFF)) begin
        fails++;
        $display("[TB] FAIL overrun_readback k=%0d got vld=%b pix=%h exp vld=1 pix=%h",
                 k, cap_vld[k], cap_pix[k], (k < 256) ? 8'(k) : 8'hFF);
      end
    end
  endtask

  task automatic test_transparency();
    logic exp_opq;
    do_reset();
    run_line(64, 1'b1, 1'b0, 8'h00);
    run_line(64, 1'b1, 1'b0, 8'h30);
    for (int k = 0; k < 64; k++) begin
      exp_opq = (k % 16) != 15;
      tests++;
      if (cap_pix[k] !== 8'(k) || cap_opq[k] !== exp_opq) begin
        fails++;
        $display("[TB] FAIL opq_flag k=%0d got pix=%h opq=%b exp pix=%h opq=%b",
                 k, cap_pix[k], cap_opq[k], 8'(k), exp_opq);
      end
    end
    tests++;
    if (cap_opq[8'h3F] !== 1'b0 || cap_opq[8'h3E] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL opq_3f_3e got %b/%b exp 0/1", cap_opq[8'h3F], cap_opq[8'h3E]);
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    run_line(256, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 54; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 50) begin
        tests++;
        if (B1_VALID !== 1'b1 || B1_PIX !== 8'(k - 2)) begin
          fails++;
          $display("[TB] FAIL midline_before k=%0d got vld=%b pix=%h exp vld=1 pix=%h",
                   k - 2, B1_VALID, B1_PIX, 8'(k - 2));
        end
      end
      if (k >= 51) begin
        tests++;
        if (B1_VALID !== 1'b0 || B1_PIX !== 8'hFF || SHORT_LINE !== 1'b0) begin
          fails++;
          $display("[TB] FAIL midline_flush cyc=%0d got vld=%b pix=%h short=%b exp vld=0 pix=ff short=0",
                   k, B1_VALID, B1_PIX, SHORT_LINE);
        end
      end
      VIDEO_RSTn = (k != 50);
      CK1n       = (k <= 50);
      LSTART     = (k == 0);
      INV        = 1'b0;
      B1D        = 8'(k) ^ 8'h99;
    end
    run_line(256, 1'b1, 1'b0, 8'h00);
    tests++;
    if (short_cnt !== 0) begin
      fails++;
      $display("[TB] FAIL midline_no_short got %0d exp 0", short_cnt);
    end
    for (int k = 0; k < 50; k++) begin
      tests++;
      if (cap_vld[k] !== 1'b1 || cap_pix[k] !== (8'(k) ^ 8'h99)) begin
        fails++;
        $display("[TB] FAIL midline_retained k=%0d got vld=%b pix=%h exp vld=1 pix=%h",
                 k, cap_vld[k], cap_pix[k], 8'(k) ^ 8'h99);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_readback();
    test_flip();
    test_short_line();
    test_overrun();
    test_transparency();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tnkiii_back1_linebuf.md
TNKIII_BACK1_LINEBUF -- requirements
Module: tnkiii_back1_linebuf

Interface
REQ-001 Parameter LINE_W, default 256, meaning pixels stored per scanline (power of two, 64..256).
REQ-002 Parameter TRANS_PEN, default 4'hF, meaning pen value of B1D[3:0] treated as transparent.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 VIDEO_RSTn  input  1  reset; synchronous and active-low.
REQ-005 CK1n  input  1  one-clk pixel strobe; each strobe carries one pixel.
REQ-006 LSTART  input  1  one-clk pulse marking the first pixel strobe of a scanline.
REQ-007 INV  input  1  flip-screen; when 1, the read-out order is mirrored.
REQ-008 B1D  input  8  Back1 pixel from the tile stage: [7:4] palette bank, [3:0] pen.
REQ-009 B1_PIX  output  8  buffered pixel of the previous scanline.
REQ-010 B1_OPQ  output  1  1 when B1_PIX[3:0] != TRANS_PEN.
REQ-011 B1_VALID  output  1  one-clk pulse when B1_PIX/B1_OPQ update.
REQ-012 SHORT_LINE  output  1  one-clk pulse when LSTART arrives before LINE_W pixels were written.

Function
REQ-013 Two line banks (ping-pong); bank_sel selects the write bank, and the read bank is always !bank_sel.
REQ-014 On LSTART, bank_sel toggles, and wr_cnt and rd_cnt are reloaded so that the coincident strobe uses address 0.
REQ-015 Each CK1n writes B1D to the write bank at wr_cnt; wr_cnt then increments.
REQ-016 When wr_cnt reaches LINE_W, wr_cnt saturates and further strobes in that line are not written (no wrap).
REQ-017 Each CK1n reads the read bank at rd_addr = INV ? (LINE_W-1-rd_cnt) : rd_cnt; rd_cnt then increments.
REQ-018 rd_cnt saturates at LINE_W; strobes beyond LINE_W return 8'hFF and produce B1_VALID.
REQ-019 Read latency is exactly 2 clk from the CK1n strobe to B1_PIX/B1_VALID: one clk for the registered RAM address and one for the output register.
REQ-020 B1_PIX and B1_OPQ hold their value between B1_VALID pulses.
REQ-021 A strobe coincident with LSTART is treated as pixel 0 of the new line, both for write and for read.
REQ-022 SHORT_LINE pulses 1 clk after an LSTART whose previous line had wr_cnt < LINE_W.
REQ-023 SHORT_LINE does not pulse on the first LSTART after reset.
REQ-024 Pixels not written in a short line retain stale contents; no clearing is performed.
REQ-025 An INV change mid-line takes effect on the next strobe; no resynchronisation is performed.
REQ-026 The two banks never alias: write and read in the same clk always target different banks.

Reset
REQ-027 While VIDEO_RSTn = 0 at a clk edge, reset values are:
- bank_sel = 0
- wr_cnt = LINE_W (saturated)
- rd_cnt = LINE_W (saturated)
- B1_PIX = 8'hFF
- B1_OPQ = 0
- B1_VALID = 0
- SHORT_LINE = 0
REQ-028 RAM contents are not reset.
REQ-029 Strobes before the first LSTART after reset write nothing and read 8'hFF.
REQ-030 Reset asserted mid-line aborts the line; the pipeline is flushed with no B1_VALID pulse for strobes issued in the 2 clk before reset.

Structure
REQ-031 LINE_W default, TRANS_PEN default and the 8'hFF blank pixel constant are defined in the shared package tnkiii_video_pkg.
REQ-032 Storage is one SRAM_dual_sync instance, ADDR_WIDTH = log2(LINE_W)+1 with the bank bit as address MSB.
REQ-033 In that instance, port 0 is write-only and port 1 is read-only.
REQ-034 No other sub-module is used; counters, flip mux and the output register are local logic.

Verification
REQ-035 Initial line fill and read-back:
- Stimulus: reset, LSTART, 256 strobes with B1D = pixel index; then LSTART, 256 strobes with INV = 0.
- Response: B1_PIX = 0x00..0xFF in order, each 2 clk after its strobe.
REQ-036 Flip read-out:
- Stimulus: same two lines as REQ-035 with INV = 1 during the second line.
- Response: B1_PIX = 0xFF, 0xFE, .. 0x00.
REQ-037 Short line:
- Stimulus: LSTART, 100 strobes, LSTART.
- Response: SHORT_LINE pulses once, 1 clk after the second LSTART.
- Response: next-line reads at addresses 100..255 return stale data from the earlier line.
REQ-038 Overrun:
- Stimulus: 300 strobes in one line.
- Response: writes stop at 256, and addresses 0..255 are intact on read-back.
- Response: read strobes 257..300 give 8'hFF with B1_VALID pulses.
REQ-039 Transparency flag:
- Stimulus: B1D = 8'h3F.
- Response: B1_OPQ = 0.
- Stimulus: B1D = 8'h3E.
- Response: B1_OPQ = 1.
REQ-040 Reset mid-line:
- Stimulus: assert VIDEO_RSTn = 0 for 1 clk at pixel 50.
- Response: B1_PIX = 8'hFF and B1_VALID = 0 until the first valid read after the next LSTART.
- Response: no SHORT_LINE on that LSTART.
